mcdf_reg_cmd_master: RTL



---
 rtl/mcdf_reg_pkg.sv | 27 ++
 rtl/mcdf_reg_req_fifo.sv | 55 +++++
 rtl/mcdf_reg_cmd_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mcdf_reg_pkg.sv
// Shared definitions for the MCDF control-register command interface:
// command codes, register map and the command-master FSM states.
package mcdf_reg_pkg;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    localparam int NUM_REGS = 6;
    localparam int RO_BASE  = 3;

    localparam logic [5:0] ADDR_CTRL0 = 6'h00;
    localparam logic [5:0] ADDR_CTRL1 = 6'h04;
    localparam logic [5:0] ADDR_CTRL2 = 6'h08;
    localparam logic [5:0] ADDR_STAT0 = 6'h0C;
    localparam logic [5:0] ADDR_STAT1 = 6'h10;
    localparam logic [5:0] ADDR_STAT2 = 6'h14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_WR,
        ST_CMD_RD,
        ST_CAPT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mcdf_reg_req_fifo.sv
// Synchronous request FIFO holding packed {wr, addr, wdata} entries.
// Head entry is visible combinationally on pop_data_o while not empty.
module mcdf_reg_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mcdf_reg_cmd_master.sv
// Command initiator for the MCDF register block: queues host requests,
// rejects illegal accesses, issues one RD/WR command at a time and
// returns in-order responses with captured read data.
module mcdf_reg_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = mcdf_reg_pkg::NUM_REGS,
    parameter int RO_BASE    = mcdf_reg_pkg::RO_BASE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [1:0]        cmd_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [DATA_W-1:0] cmd_data_o,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              busy_o
);
    import mcdf_reg_pkg::*;

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [31:0]        head_idx;
    logic               head_err;

    state_e             state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    mcdf_reg_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i ({req_wr_i, req_addr_i, req_wdata_i}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign req_ready_o = !fifo_full;
    assign fifo_push   = req_valid_i && !fifo_full;
    assign busy_o      = (state_q != ST_IDLE) || (fifo_count != '0);

    // Access rules the register block itself does not enforce.
    assign {head_wr, head_addr, head_wdata} = fifo_head;
    assign head_idx = 32'(head_addr[ADDR_W-1:2]);
    assign head_err = (head_addr[1:0] != 2'b00) ||
                      (head_idx >= 32'(NUM_REGS)) ||
                      (head_wr && (head_idx >= 32'(RO_BASE)));

    assign cmd_o       = cmd_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_data_o  = data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // State and registered outputs; outputs are loaded with next-state values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output decode; command bus idles to zero by default.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        cmd_d       = CMD_IDLE;
        addr_d      = '0;
        data_d      = '0;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        rdata_d     = '0;
                    end else if (head_wr) begin
                        state_d = ST_CMD_WR;
                        cmd_d   = CMD_WR;
                        addr_d  = head_addr;
                        data_d  = head_wdata;
                    end else begin
                        state_d = ST_CMD_RD;
                        cmd_d   = CMD_RD;
                        addr_d  = head_addr;
                    end
                end
            end
            ST_CMD_WR: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                err_d       = 1'b0;
                rdata_d     = '0;
            end
            ST_CMD_RD: state_d = ST_CAPT;
            ST_CAPT: begin
                // Read data from the register block lands during this cycle.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                err_d       = 1'b0;
                rdata_d     = cmd_data_i;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    err_d       = 1'b0;
                    rdata_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
